// File: rtl/send_pkt_pkg.sv
// Shared types and helpers for the send-side frame packer.
// Frame layout: SOF0 SOF1 SEQ LEN payload... CSUM.
package send_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    SEQ,
    LEN,
    PAYLOAD,
    CSUM
  } state_e;

  localparam logic [7:0] SOF0_DEFAULT = 8'h55;
  localparam logic [7:0] SOF1_DEFAULT = 8'hAA;
  localparam int         LEN_W        = 8;

  function automatic logic [LEN_W-1:0] frameLen(input int unsigned words);
    logic [31:0] total;
    total = words << 2;
    return total[LEN_W-1:0];
  endfunction

  // Byte index 0 is the first byte on the wire for the selected order.
  function automatic logic [7:0] pickByte(input logic [31:0] word,
                                          input logic [1:0]  idx,
                                          input logic        msbFirst);
    logic [1:0] lane;
    lane = msbFirst ? (2'd3 - idx) : idx;
    case (lane)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

endpackage

// File: rtl/send_frame_packer.sv
// Pops 32-bit words from a prefetch FIFO and serialises them into framed
// byte packets on a valid/ready stream, one byte per cycle at full rate.
module send_frame_packer
  import send_pkt_pkg::*;
#(
  parameter int          PAYLOAD_WORDS = 16,
  parameter bit          MSB_FIRST     = 1'b1,
  parameter logic [7:0]  SOF0          = SOF0_DEFAULT,
  parameter logic [7:0]  SOF1          = SOF1_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_rd_vld,
  input  logic [31:0] fifo_rd_data,
  output logic        fifo_rd_en,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done
);

  if (PAYLOAD_WORDS < 1 || PAYLOAD_WORDS > 63) begin : gBadPayloadWords
    $fatal(1, "send_frame_packer: PAYLOAD_WORDS must be within 1..63");
  end

  localparam logic [6:0]       POP_QUOTA = 7'(PAYLOAD_WORDS);
  localparam logic [LEN_W-1:0] LEN_BYTE  = frameLen(32'(PAYLOAD_WORDS));

  state_e      state_q;
  logic [7:0]  txData_q;
  logic        txValid_q;
  logic        busy_q;
  logic        frameDone_q;
  logic [7:0]  seq_q;
  logic [7:0]  csum_q;
  logic [31:0] wordBuf_q;
  logic        bufFull_q;
  logic [1:0]  byteIdx_q;
  logic [6:0]  popCnt_q;

  logic [7:0]  csum_d;
  logic        fire;
  logic        lastByteFire;
  logic        popWindow;
  logic        startFrame;

  // A pop refills the single-word buffer either when it is empty or in the
  // same cycle its last byte leaves, so consecutive words have no bubble.
  always_comb begin
    fire         = txValid_q & tx_ready;
    lastByteFire = fire && (state_q == PAYLOAD) && (byteIdx_q == 2'd3);
    popWindow    = state_q inside {HDR0, HDR1, SEQ, LEN, PAYLOAD};
    fifo_rd_en   = fifo_rd_vld && popWindow && (popCnt_q < POP_QUOTA) &&
                   (!bufFull_q || lastByteFire);
    csum_d       = csum_q + txData_q;
    startFrame   = fifo_rd_vld &&
                   ((state_q == IDLE) || ((state_q == CSUM) && fire));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      txData_q    <= '0;
      txValid_q   <= 1'b0;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
      seq_q       <= '0;
      csum_q      <= '0;
      wordBuf_q   <= '0;
      bufFull_q   <= 1'b0;
      byteIdx_q   <= '0;
      popCnt_q    <= '0;
    end else begin
      frameDone_q <= 1'b0;
      if (fifo_rd_en) begin
        wordBuf_q <= fifo_rd_data;
        bufFull_q <= 1'b1;
        byteIdx_q <= 2'd0;
        popCnt_q  <= popCnt_q + 7'd1;
      end
      case (state_q)
        IDLE: begin
        end
        HDR0: if (fire) begin
          state_q  <= HDR1;
          txData_q <= SOF1;
        end
        HDR1: if (fire) begin
          state_q  <= SEQ;
          txData_q <= seq_q;
        end
        SEQ: if (fire) begin
          state_q  <= LEN;
          txData_q <= LEN_BYTE;
          csum_q   <= csum_d;
        end
        LEN: if (fire) begin
          state_q <= PAYLOAD;
          csum_q  <= csum_d;
          if (bufFull_q)       txData_q  <= pickByte(wordBuf_q, 2'd0, MSB_FIRST);
          else if (fifo_rd_en) txData_q  <= pickByte(fifo_rd_data, 2'd0, MSB_FIRST);
          else                 txValid_q <= 1'b0;
        end
        // The presented byte is buffer[byteIdx]; an empty buffer means a stall.
        PAYLOAD: begin
          if (fire) begin
            csum_q <= csum_d;
            if (byteIdx_q != 2'd3) begin
              byteIdx_q <= byteIdx_q + 2'd1;
              txData_q  <= pickByte(wordBuf_q, byteIdx_q + 2'd1, MSB_FIRST);
            end else if (popCnt_q == POP_QUOTA) begin
              state_q   <= CSUM;
              txData_q  <= csum_d;
              bufFull_q <= 1'b0;
            end else if (fifo_rd_en) begin
              txData_q <= pickByte(fifo_rd_data, 2'd0, MSB_FIRST);
            end else begin
              bufFull_q <= 1'b0;
              txValid_q <= 1'b0;
            end
          end else if (!txValid_q && fifo_rd_en) begin
            txValid_q <= 1'b1;
            txData_q  <= pickByte(fifo_rd_data, 2'd0, MSB_FIRST);
          end
        end
        CSUM: if (fire) begin
          state_q     <= IDLE;
          txValid_q   <= 1'b0;
          busy_q      <= 1'b0;
          frameDone_q <= 1'b1;
          seq_q       <= seq_q + 8'd1;
        end
        default: state_q <= IDLE;
      endcase
      // Also covers the back-to-back case straight out of CSUM.
      if (startFrame) begin
        state_q   <= HDR0;
        txValid_q <= 1'b1;
        txData_q  <= SOF0;
        busy_q    <= 1'b1;
        csum_q    <= '0;
        popCnt_q  <= '0;
        bufFull_q <= 1'b0;
      end
    end
  end

  assign tx_data    = txData_q;
  assign tx_valid   = txValid_q;
  assign busy       = busy_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_send_frame_packer.sv
// Self-checking bench for send_frame_packer: a FIFO model feeds words while a
// scoreboard of expected frame bytes is compared against every accepted byte.
module tb_send_frame_packer;

  localparam int PW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifoRdVld = 1'b0;
  logic [31:0] fifoRdData = '0;
  logic        fifoRdEn;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady = 1'b0;
  logic        busy;
  logic        frameDone;

  logic        lVld = 1'b0;
  logic [31:0] lData = '0;
  logic        lRdEn;
  logic [7:0]  lTxData;
  logic        lTxValid;
  logic        lReady = 1'b0;
  logic        lBusy;
  logic        lDone;

  send_frame_packer #(.PAYLOAD_WORDS(PW), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .fifo_rd_vld(fifoRdVld), .fifo_rd_data(fifoRdData), .fifo_rd_en(fifoRdEn),
    .tx_data(txData), .tx_valid(txValid), .tx_ready(txReady),
    .busy(busy), .frame_done(frameDone)
  );

  send_frame_packer #(.PAYLOAD_WORDS(1), .MSB_FIRST(1'b0)) dutLsb (
    .clk(clk), .rst(rst),
    .fifo_rd_vld(lVld), .fifo_rd_data(lData), .fifo_rd_en(lRdEn),
    .tx_data(lTxData), .tx_valid(lTxValid), .tx_ready(lReady),
    .busy(lBusy), .frame_done(lDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    int          readyMode;
    int          gap;
    logic [7:0]  expCsum;
    int          expBubbles;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] fifoQ[$];
  logic [7:0]  expQ[$];
  logic [7:0]  lExp[9];

  int compared = 0;
  int mismatched = 0;
  int readyMode = 0;
  int gapLen = 0;
  int gapCnt = 0;
  int cycleIdx = 0;
  int popsInFrame = 0;
  int donesInFrame = 0;
  int bytesInFrame = 0;
  int bubbles = 0;
  int midRunIdle = 0;
  logic [7:0] lastByte = '0;
  logic       prevStall = 1'b0;
  logic [7:0] prevData = '0;
  logic [7:0] modelSeq = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] laneByte(input logic [31:0] w, input int i, input bit msb);
    return msb ? w[8*(3-i) +: 8] : w[8*i +: 8];
  endfunction

  // Queue the two words for the FIFO model and the full expected frame.
  task automatic pushFrame(input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] ws[2];
    logic [7:0]  sum;
    logic [7:0]  b;
    ws[0] = w0;
    ws[1] = w1;
    fifoQ.push_back(w0);
    fifoQ.push_back(w1);
    expQ.push_back(8'h55);
    expQ.push_back(8'hAA);
    expQ.push_back(modelSeq);
    expQ.push_back(8'(4 * PW));
    sum = modelSeq + 8'(4 * PW);
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 4; i++) begin
        b = laneByte(ws[w], i, 1'b1);
        expQ.push_back(b);
        sum = sum + b;
      end
    end
    expQ.push_back(sum);
    modelSeq = modelSeq + 8'd1;
  endtask

  task automatic clearStats();
    popsInFrame = 0;
    donesInFrame = 0;
    bytesInFrame = 0;
    bubbles = 0;
    midRunIdle = 0;
    prevStall = 1'b0;
  endtask

  // Drive inputs on the falling edge, observe one time unit before the rising edge.
  task automatic applyStimulus();
    logic midRun;
    @(negedge clk);
    cycleIdx++;
    txReady = (readyMode == 0) ? 1'b1 : ((cycleIdx % 3) == 0);
    if (gapCnt > 0) begin
      fifoRdVld = 1'b0;
      gapCnt--;
    end else begin
      fifoRdVld = (fifoQ.size() > 0);
    end
    fifoRdData = (fifoQ.size() > 0) ? fifoQ[0] : '0;
    #4;
    if (prevStall) begin
      checkOutput("holdValid", 32'(txValid), 32'd1);
      checkOutput("holdData", 32'(txData), 32'(prevData));
    end
    prevStall = txValid && !txReady;
    prevData = txData;
    midRun = (bytesInFrame > 0) && (expQ.size() > 0);
    if (midRun && !(txValid && txReady)) midRunIdle++;
    if (busy && !txValid) bubbles++;
    if (frameDone) donesInFrame++;
    if (fifoRdEn && fifoRdVld) begin
      void'(fifoQ.pop_front());
      popsInFrame++;
      if (popsInFrame == 1 && gapLen > 0) gapCnt = gapLen;
    end
    if (txValid && txReady) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL extraByte: got %0h, expected no byte", txData);
      end else begin
        checkOutput("byte", 32'(txData), 32'(expQ.pop_front()));
      end
      bytesInFrame++;
      lastByte = txData;
    end
  endtask

  task automatic runFrames(input int n, input int budget);
    int cyc;
    cyc = 0;
    while ((expQ.size() > 0 || donesInFrame < n) && cyc < budget) begin
      applyStimulus();
      cyc++;
    end
    if (cyc >= budget) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL timeout: got %0d frame_done pulses, expected %0d", donesInFrame, n);
    end
  endtask

  initial begin
    vecs[0] = '{w0: 32'h01020304, w1: 32'h05060708, readyMode: 0, gap: 0,  expCsum: 8'h2C, expBubbles: 0};
    vecs[1] = '{w0: 32'h01020304, w1: 32'h05060708, readyMode: 1, gap: 0,  expCsum: 8'h2D, expBubbles: 0};
    vecs[2] = '{w0: 32'h01020304, w1: 32'h05060708, readyMode: 0, gap: 10, expCsum: 8'h2E, expBubbles: 4};
    vecs[3] = '{w0: 32'hFFFFFFFF, w1: 32'h00000001, readyMode: 0, gap: 0,  expCsum: 8'h08, expBubbles: 0};
    vecs[4] = '{w0: 32'h11223344, w1: 32'hAABBCCDD, readyMode: 1, gap: 0,  expCsum: 8'hC4, expBubbles: 0};
    lExp = '{8'h55, 8'hAA, 8'h00, 8'h04, 8'h44, 8'h33, 8'h22, 8'h11, 8'hAE};

    // Reset state, with a valid FIFO head that must not be popped.
    #1 rst = 1'b1;
    fifoRdVld = 1'b1;
    fifoRdData = 32'hDEADBEEF;
    #3;
    checkOutput("rstTxValid", 32'(txValid), 32'd0);
    checkOutput("rstTxData", 32'(txData), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstFrameDone", 32'(frameDone), 32'd0);
    checkOutput("rstRdEn", 32'(fifoRdEn), 32'd0);
    @(negedge clk);
    fifoRdVld = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      clearStats();
      readyMode = vecs[v].readyMode;
      gapLen = vecs[v].gap;
      pushFrame(vecs[v].w0, vecs[v].w1);
      runFrames(1, 300);
      checkOutput($sformatf("csum%0d", v), 32'(lastByte), 32'(vecs[v].expCsum));
      checkOutput($sformatf("pops%0d", v), popsInFrame, PW);
      checkOutput($sformatf("frameDone%0d", v), donesInFrame, 1);
      checkOutput($sformatf("bubbles%0d", v), bubbles, vecs[v].expBubbles);
      checkOutput($sformatf("bytes%0d", v), bytesInFrame, 5 + 4 * PW);
    end
    gapLen = 0;
    readyMode = 0;

    // Asynchronous reset while payload byte 2 is on the wire.
    clearStats();
    pushFrame(32'hA1A2A3A4, 32'hB1B2B3B4);
    for (int c = 0; c < 100 && bytesInFrame < 6; c++) applyStimulus();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midRstTxValid", 32'(txValid), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    fifoQ.delete();
    expQ.delete();
    fifoRdVld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelSeq = '0;
    clearStats();
    pushFrame(32'hC0C1C2C3, 32'hD0D1D2D3);
    runFrames(1, 300);
    checkOutput("postRstPops", popsInFrame, PW);
    checkOutput("postRstDone", donesInFrame, 1);

    // 257 back-to-back frames: SEQ wraps and frames abut without a gap.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelSeq = '0;
    clearStats();
    for (int f = 0; f < 257; f++) pushFrame(32'h01000000 * f + 32'h00A5005A, 32'hF0E0D0C0 ^ f);
    runFrames(257, 4000);
    checkOutput("wrapDones", donesInFrame, 257);
    checkOutput("wrapPops", popsInFrame, 257 * PW);
    checkOutput("wrapBytes", bytesInFrame, 257 * (5 + 4 * PW));
    checkOutput("wrapIdleCycles", midRunIdle, 0);
    checkOutput("wrapBubbles", bubbles, 0);

    // LSB-first instance, one payload word.
    begin
      int   lIdx;
      int   lPops;
      int   lDoneCnt;
      logic lPopped;
      lIdx = 0;
      lPops = 0;
      lDoneCnt = 0;
      lPopped = 1'b0;
      @(negedge clk);
      lReady = 1'b1;
      lVld = 1'b1;
      lData = 32'h11223344;
      for (int c = 0; c < 40; c++) begin
        #4;
        if (lRdEn && lVld) begin
          lPops++;
          lPopped = 1'b1;
        end
        if (lTxValid && lReady) begin
          if (lIdx < 9) checkOutput($sformatf("lsbByte%0d", lIdx), 32'(lTxData), 32'(lExp[lIdx]));
          lIdx++;
        end
        if (lDone) lDoneCnt++;
        @(negedge clk);
        if (lPopped) lVld = 1'b0;
      end
      checkOutput("lsbByteCount", lIdx, 9);
      checkOutput("lsbPops", lPops, 1);
      checkOutput("lsbDone", lDoneCnt, 1);
      checkOutput("lsbBusyEnd", 32'(lBusy), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
